// File: rtl/cell_cdc_hs_tx.sv
// cell_cdc_hs_tx: source side of a four-phase REQ/ACK clock-domain crossing.
// A word accepted on S_VALID/S_READY is held on DATA_OUT while REQ is high.
// The block then waits for the synchronized ACK to rise and fall again.
// Optional build macro CELL_CDC_HS_TX_TIMEOUT_EN adds a sticky timeout flag
// on ERR. Without the macro, ERR is tied to 0.
module cell_cdc_hs_tx #(
    parameter int DW        = 32,
    parameter int TO_CYCLES = 1024
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          S_VALID,
    output logic          S_READY,
    input  logic [DW-1:0] S_DATA,
    output logic          REQ,
    output logic [DW-1:0] DATA_OUT,
    input  logic          ACK,
    output logic          BUSY,
    output logic          ERR
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_AH = 2'd1,
        WAIT_AL = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic [DW-1:0] data_q, data_d;
    logic          ack_s1_q, ack_s2_q;

    // Two-flop synchronizer bringing the asynchronous ACK into the CK domain.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CK) begin
        if (RST) begin
            ack_s1_q <= 1'b0;
            ack_s2_q <= 1'b0;
        end else begin
            ack_s1_q <= ACK;
            ack_s2_q <= ack_s1_q;
        end
    end

    // State, REQ and held data registers.
    // NOTE: DATA_OUT is a plain register bank, not a memory, so it takes the reset value.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
        end
    end

    // Handshake sequencing. The FSM looks only at the synchronized ACK.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (S_VALID) begin
                    data_d  = S_DATA;
                    req_d   = 1'b1;
                    state_d = WAIT_AH;
                end
            end
            WAIT_AH: begin
                if (ack_s2_q) begin
                    req_d   = 1'b0;
                    state_d = WAIT_AL;
                end
            end
            WAIT_AL: begin
                if (!ack_s2_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign S_READY  = (state_q == IDLE);
    assign BUSY     = (state_q != IDLE);
    assign REQ      = req_q;
    assign DATA_OUT = data_q;

`ifdef CELL_CDC_HS_TX_TIMEOUT_EN
    localparam int            CW     = $clog2(TO_CYCLES) + 1;
    localparam logic [CW-1:0] TO_MAX = CW'(TO_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Wait-time counter. It restarts on every state change and saturates at the
    // threshold. ERR latches on the edge where the count reaches the threshold.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE || state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != TO_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        err_d = err_q | (cnt_d == TO_MAX);
    end

    // Timeout counter and sticky error flag.
    always_ff @(posedge CK) begin
        if (RST) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`else
    // The threshold matters only in the timeout build.
    logic unused_to_cycles;
    assign unused_to_cycles = (TO_CYCLES >= 4);
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_cell_cdc_hs_tx.sv
// Testbench for cell_cdc_hs_tx. It uses a vector table for the reset, single
// transfer and IDLE-glitch cases. Hand sequences cover reset mid-transfer and
// timeout. A combined driver/responder/scoreboard loop covers stall and
// random-latency traffic.
module tb_cell_cdc_hs_tx;

    localparam int DW = 32;
`ifdef CELL_CDC_HS_TX_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic          CK;
    logic          RST;
    logic          S_VALID;
    logic          S_READY;
    logic [DW-1:0] S_DATA;
    logic          REQ;
    logic [DW-1:0] DATA_OUT;
    logic          ACK;
    logic          BUSY;
    logic          ERR;

    int total = 0;
    int bad   = 0;

    cell_cdc_hs_tx #(.DW(DW), .TO_CYCLES(16)) dut (
        .CK       (CK),
        .RST      (RST),
        .S_VALID  (S_VALID),
        .S_READY  (S_READY),
        .S_DATA   (S_DATA),
        .REQ      (REQ),
        .DATA_OUT (DATA_OUT),
        .ACK      (ACK),
        .BUSY     (BUSY),
        .ERR      (ERR)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    // Global time limit in case the DUT wedges somewhere unexpected.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] data;
        logic        ack;
        logic        exp_req;
        logic        exp_rdy;
        logic        exp_busy;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, input logic valid, input logic [31:0] data,
                                input logic ack, input logic exp_req, input logic exp_rdy,
                                input logic exp_busy, input logic [31:0] exp_dout);
        vec_t v;
        v.rst = rst; v.valid = valid; v.data = data; v.ack = ack;
        v.exp_req = exp_req; v.exp_rdy = exp_rdy; v.exp_busy = exp_busy; v.exp_dout = exp_dout;
        tbl.push_back(v);
    endfunction

    // Driver, four-phase responder and scoreboard in one cycle loop.
    // Words are queued when presented and popped at each REQ rise.
    task automatic run_traffic(input int n, input int gap_pct, input bit junk,
                               input int dmin, input int dmax, input string tag);
        logic [31:0] exp_q[$];
        logic [31:0] cur, held, exp;
        bit   have_held, rdy_prev, req_prev;
        int   sent, seen, budget, limit, ph, cnt;
        cur = '0; held = '0; have_held = 0; sent = 0; seen = 0; budget = 0;
        ph = 0; cnt = 0;
        limit = n * 80 + 200;
        ACK = 1'b0;
        S_VALID = 1'b0;
        rdy_prev = S_READY;
        req_prev = REQ;
        while ((seen < n || ph != 0 || BUSY) && budget < limit) begin
            tick();
            budget++;
            // Monitor: the first REQ-high cycle must carry the next queued word.
            if (REQ && !req_prev) begin
                check({tag, "_req_rise_ack_low"}, 32'(ACK), 32'd0);
                if (exp_q.size() == 0) begin
                    check({tag, "_unexpected_req"}, 32'd1, 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check({tag, "_dout_at_req"}, DATA_OUT, exp);
                    held = exp;
                    have_held = 1;
                end
                seen++;
            end else if (have_held) begin
                check({tag, "_dout_hold"}, DATA_OUT, held);
            end
            req_prev = REQ;
            // Source driver.
            if (S_VALID && rdy_prev) S_VALID = 1'b0;
            if (!S_VALID && sent < n && $urandom_range(99, 0) >= gap_pct) begin
                cur = $urandom;
                exp_q.push_back(cur);
                S_VALID = 1'b1;
                sent++;
            end
            if (S_VALID) S_DATA = (junk && !S_READY) ? $urandom : cur;
            rdy_prev = S_READY;
            // Destination responder with a random delay on each ACK edge.
            case (ph)
                0: if (REQ)  begin cnt = $urandom_range(dmax, dmin); ph = 1; end
                2: if (!REQ) begin cnt = $urandom_range(dmax, dmin); ph = 3; end
                default: ;
            endcase
            if (ph == 1) begin
                if (cnt == 0) begin ACK = 1'b1; ph = 2; end else cnt--;
            end else if (ph == 3) begin
                if (cnt == 0) begin ACK = 1'b0; ph = 0; end else cnt--;
            end
        end
        check({tag, "_within_budget"}, 32'(budget < limit), 32'd1);
        check({tag, "_req_pulses"}, 32'(seen), 32'(n));
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        S_VALID = 1'b0;
    endtask

    initial begin
        RST = 1'b1; S_VALID = 1'b0; S_DATA = '0; ACK = 1'b0;

        // Reset state, single transfer with ACK after 7 cycles, data change
        // while busy, then a 3-cycle ACK glitch in IDLE.
        add(1, 0, 32'h0,        0, 0, 1, 0, 32'h0);
        add(0, 1, 32'hDEADBEEF, 0, 1, 0, 1, 32'hDEADBEEF);
        add(0, 1, 32'h11111111, 0, 1, 0, 1, 32'hDEADBEEF);
        for (int i = 0; i < 6; i++)
            add(0, 0, 32'h22222222, 0, 1, 0, 1, 32'hDEADBEEF);
        add(0, 0, 32'h0, 1, 1, 0, 1, 32'hDEADBEEF);
        add(0, 0, 32'h0, 1, 1, 0, 1, 32'hDEADBEEF);
        add(0, 0, 32'h0, 1, 0, 0, 1, 32'hDEADBEEF);
        add(0, 0, 32'h0, 1, 0, 0, 1, 32'hDEADBEEF);
        add(0, 0, 32'h0, 0, 0, 0, 1, 32'hDEADBEEF);
        add(0, 0, 32'h0, 0, 0, 0, 1, 32'hDEADBEEF);
        add(0, 0, 32'h0, 0, 0, 1, 0, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++)
            add(0, 0, 32'h33333333, 1, 0, 1, 0, 32'hDEADBEEF);
        add(0, 0, 32'h0, 0, 0, 1, 0, 32'hDEADBEEF);
        add(0, 0, 32'h0, 0, 0, 1, 0, 32'hDEADBEEF);

        for (int i = 0; i < tbl.size(); i++) begin
            RST = tbl[i].rst; S_VALID = tbl[i].valid; S_DATA = tbl[i].data; ACK = tbl[i].ack;
            tick();
            check($sformatf("vec%0d_req", i),   32'(REQ),     32'(tbl[i].exp_req));
            check($sformatf("vec%0d_rdy", i),   32'(S_READY), 32'(tbl[i].exp_rdy));
            check($sformatf("vec%0d_busy", i),  32'(BUSY),    32'(tbl[i].exp_busy));
            check($sformatf("vec%0d_dout", i),  DATA_OUT,     tbl[i].exp_dout);
            check($sformatf("vec%0d_err", i),   32'(ERR),     32'd0);
        end
        RST = 1'b0; S_VALID = 1'b0; ACK = 1'b0;

        // Stall/hold: S_VALID held high, S_DATA scrambled while busy.
        run_traffic(8, 0, 1'b1, 3, 3, "stall");

        // Reset while waiting for ACK high.
        S_VALID = 1'b1; S_DATA = 32'hA5A50F0F;
        tick();
        check("rstmid_req_up", 32'(REQ), 32'd1);
        S_VALID = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rstmid_req", 32'(REQ), 32'd0);
        check("rstmid_dout", DATA_OUT, 32'd0);
        check("rstmid_rdy", 32'(S_READY), 32'd1);
        check("rstmid_busy", 32'(BUSY), 32'd0);
        run_traffic(2, 0, 1'b0, 0, 5, "post_rst");

        // Timeout: ACK withheld for well past the 16-cycle threshold.
        S_VALID = 1'b1; S_DATA = 32'h0BADF00D; ACK = 1'b0;
        tick();
        S_VALID = 1'b0;
        repeat (15) tick();
        check("to_before", 32'(ERR), 32'd0);
        tick();
        check("to_at16", 32'(ERR), 32'(TO_EN));
        check("to_req_still_up", 32'(REQ), 32'd1);
        repeat (10) tick();
        check("to_sticky", 32'(ERR), 32'(TO_EN));
        ACK = 1'b1;
        repeat (3) tick();
        check("to_req_fall", 32'(REQ), 32'd0);
        ACK = 1'b0;
        repeat (3) tick();
        check("to_rdy_after_hs", 32'(S_READY), 32'd1);
        check("to_err_after_hs", 32'(ERR), 32'(TO_EN));
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("to_err_cleared", 32'(ERR), 32'd0);

        // Random destination latency, random source gaps.
        run_traffic(1000, 40, 1'b0, 0, 20, "rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
